// File: rtl/lab3_mem_memreq_arbiter.sv
// lab3_mem_memreq_arbiter: round-robin merge of two bank memreq streams with in-order response steering
module lab3_mem_memreq_arbiter #(
  parameter int p_req_nbits  = 175,
  parameter int p_resp_nbits = 145,
  parameter int p_max_inflt  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in0_req_val,
  output logic                    in0_req_rdy,
  input  logic [p_req_nbits-1:0]  in0_req_msg,
  input  logic                    in1_req_val,
  output logic                    in1_req_rdy,
  input  logic [p_req_nbits-1:0]  in1_req_msg,
  output logic                    in0_resp_val,
  input  logic                    in0_resp_rdy,
  output logic [p_resp_nbits-1:0] in0_resp_msg,
  output logic                    in1_resp_val,
  input  logic                    in1_resp_rdy,
  output logic [p_resp_nbits-1:0] in1_resp_msg,
  output logic                    memreq_val,
  input  logic                    memreq_rdy,
  output logic [p_req_nbits-1:0]  memreq_msg,
  input  logic                    memresp_val,
  output logic                    memresp_rdy,
  input  logic [p_resp_nbits-1:0] memresp_msg
);
  localparam int AW = $clog2(p_max_inflt);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX = CW'(p_max_inflt);
  logic [p_max_inflt-1:0] ids_q, ids_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic prio_q, prio_d;
  logic full, empty, gnt0, gnt1, push, pop, head;
  // grant selection, request handshake and response steering
  always_comb begin
    full = count_q == MAX;
    empty = count_q == '0;
    gnt0 = in0_req_val & (~prio_q | ~in1_req_val);
    gnt1 = in1_req_val & (prio_q | ~in0_req_val);
    memreq_val = ~full & (in0_req_val | in1_req_val);
    memreq_msg = gnt1 ? in1_req_msg : in0_req_msg;
    in0_req_rdy = ~full & gnt0 & memreq_rdy;
    in1_req_rdy = ~full & gnt1 & memreq_rdy;
    push = memreq_val & memreq_rdy;
    head = ids_q[rd_ptr_q];
    in0_resp_val = memresp_val & ~empty & ~head;
    in1_resp_val = memresp_val & ~empty & head;
    in0_resp_msg = memresp_msg;
    in1_resp_msg = memresp_msg;
    memresp_rdy = ~empty & (head ? in1_resp_rdy : in0_resp_rdy);
    pop = memresp_val & memresp_rdy;
  end
  // ID FIFO bookkeeping and priority rotation after each issued request
  always_comb begin
    ids_d = ids_q;
    ids_d[wr_ptr_q] = push ? gnt1 : ids_q[wr_ptr_q];
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    prio_d = push ? ~gnt1 : prio_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ids_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      prio_q <= 1'b0;
    end else begin
      ids_q <= ids_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      prio_q <= prio_d;
    end
  end
  // memory must never answer with nothing outstanding
  assert property (@(posedge clk) disable iff (reset) !(memresp_val && empty))
    else $error("memresp_val asserted while no request is outstanding");
endmodule

// File: tb/tb_lab3_mem_memreq_arbiter.sv
// tb_lab3_mem_memreq_arbiter: randomized and directed checking of the memreq arbiter against a queue model
module tb_lab3_mem_memreq_arbiter;
  localparam int RQ = 175;
  localparam int RS = 145;
  typedef logic [RQ-1:0] req_t;
  typedef logic [RS-1:0] resp_t;
  logic clk = 0, reset = 1;
  logic in0_req_val = 0, in0_req_rdy, in1_req_val = 0, in1_req_rdy;
  req_t in0_req_msg = '0, in1_req_msg = '0, memreq_msg;
  logic in0_resp_val, in0_resp_rdy = 0, in1_resp_val, in1_resp_rdy = 0;
  resp_t in0_resp_msg, in1_resp_msg, memresp_msg = '0;
  logic memreq_val, memreq_rdy = 0, memresp_val = 0, memresp_rdy;
  always #5 clk = ~clk;
  lab3_mem_memreq_arbiter dut (
    .clk(clk), .reset(reset),
    .in0_req_val(in0_req_val), .in0_req_rdy(in0_req_rdy), .in0_req_msg(in0_req_msg),
    .in1_req_val(in1_req_val), .in1_req_rdy(in1_req_rdy), .in1_req_msg(in1_req_msg),
    .in0_resp_val(in0_resp_val), .in0_resp_rdy(in0_resp_rdy), .in0_resp_msg(in0_resp_msg),
    .in1_resp_val(in1_resp_val), .in1_resp_rdy(in1_resp_rdy), .in1_resp_msg(in1_resp_msg),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg)
  );
  int checks = 0, failures = 0, cyc = 0, dlv0 = 0, dlv1 = 0;
  req_t src0[$], src1[$], memq[$];
  resp_t exp0[$], exp1[$];
  bit idq[$];
  bit glog[$];
  int fcyc[$];
  bit prio = 0;
  task automatic chk(string nm, logic [191:0] act, logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic req_t mk_req(bit wr, logic [7:0] op, logic [31:0] a, logic [127:0] d);
    return {2'b00, wr, op, a, 4'd0, d};
  endfunction
  function automatic resp_t mk_resp(req_t r);
    return {r[174:172], r[171:164], 2'b00, r[131:128], r[127:0] ^ {4{r[163:132]}}};
  endfunction
  task automatic load(bit b, bit wr, logic [7:0] op, logic [31:0] a);
    req_t r;
    r = mk_req(wr, op, a, {$urandom, $urandom, $urandom, $urandom});
    if (b) src1.push_back(r); else src0.push_back(r);
  endtask
  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1;
      in0_req_val = 0; in1_req_val = 0; memreq_rdy = 0; memresp_val = 0;
      in0_resp_rdy = 0; in1_resp_rdy = 0;
      #4;
      chk("rst_memreq_val", memreq_val, 0);
      chk("rst_in0_req_rdy", in0_req_rdy, 0);
      chk("rst_in1_req_rdy", in1_req_rdy, 0);
      chk("rst_in0_resp_val", in0_resp_val, 0);
      chk("rst_in1_resp_val", in1_resp_val, 0);
      chk("rst_memresp_rdy", memresp_rdy, 0);
    end
    src0.delete(); src1.delete(); memq.delete(); exp0.delete(); exp1.delete();
    idq.delete(); glog.delete(); fcyc.delete();
    prio = 0; dlv0 = 0; dlv1 = 0;
  endtask
  task automatic cycle(bit e0, bit e1, bit mr, bit ms, bit r0, bit r1);
    bit v0, v1, mv, full, empty, head, g0, g1, emv, emr;
    req_t m0, m1, q;
    resp_t rm;
    @(posedge clk); #1;
    cyc++;
    reset = 0;
    v0 = e0 && src0.size() > 0;
    v1 = e1 && src1.size() > 0;
    m0 = v0 ? src0[0] : RQ'($urandom);
    m1 = v1 ? src1[0] : RQ'($urandom);
    mv = ms && memq.size() > 0;
    rm = mv ? mk_resp(memq[0]) : '0;
    in0_req_val = v0; in1_req_val = v1; in0_req_msg = m0; in1_req_msg = m1;
    memreq_rdy = mr; memresp_val = mv; memresp_msg = rm;
    in0_resp_rdy = r0; in1_resp_rdy = r1;
    #4;
    full = idq.size() == 4;
    empty = idq.size() == 0;
    head = empty ? 1'b0 : idq[0];
    g0 = v0 && (!prio || !v1);
    g1 = v1 && (prio || !v0);
    emv = !full && (v0 || v1);
    emr = !empty && (head ? r1 : r0);
    chk("memreq_val", memreq_val, emv);
    chk("in0_req_rdy", in0_req_rdy, emv && g0 && mr);
    chk("in1_req_rdy", in1_req_rdy, emv && g1 && mr);
    chk("in0_resp_val", in0_resp_val, mv && !empty && !head);
    chk("in1_resp_val", in1_resp_val, mv && !empty && head);
    chk("memresp_rdy", memresp_rdy, emr);
    if (emv) chk("memreq_msg", memreq_msg, g1 ? m1 : m0);
    if (mv && !empty && !head) chk("in0_resp_msg", in0_resp_msg, rm);
    if (mv && !empty && head) chk("in1_resp_msg", in1_resp_msg, rm);
    if (mv && emr) begin
      if (head) begin
        chk("bank1_resp_sb", in1_resp_msg, exp1[0]);
        void'(exp1.pop_front());
        dlv1++;
      end else begin
        chk("bank0_resp_sb", in0_resp_msg, exp0[0]);
        void'(exp0.pop_front());
        dlv0++;
      end
      void'(idq.pop_front());
      void'(memq.pop_front());
    end
    if (emv && mr) begin
      q = g1 ? m1 : m0;
      idq.push_back(g1);
      memq.push_back(q);
      glog.push_back(g1);
      fcyc.push_back(cyc);
      prio = !g1;
      if (g1) begin
        exp1.push_back(mk_resp(q));
        void'(src1.pop_front());
      end else begin
        exp0.push_back(mk_resp(q));
        void'(src0.pop_front());
      end
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((src0.size() + src1.size() + idq.size()) != 0 && n < 400) begin
      cycle(1, 1, 1, 1, 1, 1);
      n++;
    end
    chk("drain_done", src0.size() + src1.size() + idq.size(), 0);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    do_reset(2);
    cycle(0, 0, 1, 0, 1, 1);
    chk("idle_memreq_val", memreq_val, 0);
    chk("idle_in0_req_rdy", in0_req_rdy, 0);
    chk("idle_in1_req_rdy", in1_req_rdy, 0);
    chk("idle_memresp_rdy", memresp_rdy, 0);
    // single bank, three back-to-back reads with an immediate memory
    for (int i = 0; i < 3; i++) load(0, 0, 8'(i), 32'h1000 + 32'(i) * 32'h10);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, 1, 1);
    drain();
    chk("single_grants", {glog[0], glog[1], glog[2]}, 3'b000);
    chk("single_consecutive", fcyc[2] - fcyc[0], 2);
    chk("single_dlv0", dlv0, 3);
    chk("single_dlv1", dlv1, 0);
    // contention and full
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      load(0, 0, 8'h10 + 8'(i), 32'h2000 + 32'(i) * 32'h10);
      load(1, 1, 8'h20 + 8'(i), 32'h3000 + 32'(i) * 32'h10);
    end
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 1, 1);
    chk("contention_order", {glog[0], glog[1], glog[2], glog[3]}, 4'b0101);
    cycle(1, 1, 1, 0, 1, 1);
    chk("full_blocks", memreq_val, 0);
    cycle(1, 1, 1, 1, 1, 1);
    chk("full_pop_no_push", memreq_val, 0);
    chk("full_pop_rdy", memresp_rdy, 1);
    cycle(1, 1, 1, 0, 1, 1);
    chk("after_pop_issue", memreq_val, 1);
    chk("after_pop_bank0", in0_req_rdy, 1);
    cycle(1, 1, 1, 0, 1, 1);
    chk("refull_blocks", memreq_val, 0);
    chk("full_fire_count", glog.size(), 5);
    drain();
    chk("contention_dlv0", dlv0, 4);
    chk("contention_dlv1", dlv1, 4);
    // response backpressure from bank 1
    do_reset(1);
    load(1, 0, 8'h31, 32'h4000);
    load(0, 0, 8'h30, 32'h5000);
    cycle(0, 1, 1, 0, 1, 1);
    cycle(1, 0, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 1, 0);
      chk("bp_memresp_rdy", memresp_rdy, 0);
      chk("bp_in0_resp_val", in0_resp_val, 0);
    end
    chk("bp_nothing_dlv", dlv0 + dlv1, 0);
    cycle(0, 0, 0, 1, 1, 1);
    chk("bp_release_val1", in1_resp_val, 1);
    chk("bp_release_rdy", memresp_rdy, 1);
    cycle(0, 0, 0, 1, 1, 1);
    chk("bp_next_val0", in0_resp_val, 1);
    chk("bp_dlv0", dlv0, 1);
    chk("bp_dlv1", dlv1, 1);
    // simultaneous push and pop at two outstanding
    do_reset(1);
    for (int i = 0; i < 5; i++) load(0, 1, 8'h40 + 8'(i), 32'h6000 + 32'(i) * 32'h10);
    cycle(1, 0, 1, 0, 1, 1);
    cycle(1, 0, 1, 0, 1, 1);
    cycle(1, 0, 1, 1, 1, 1);
    chk("pp_push", memreq_val & memreq_rdy, 1);
    chk("pp_pop", memresp_rdy, 1);
    cycle(1, 0, 1, 0, 1, 1);
    cycle(1, 0, 1, 0, 1, 1);
    cycle(1, 0, 1, 0, 1, 1);
    chk("pp_full_after_two", memreq_val, 0);
    chk("pp_fire_count", glog.size(), 5);
    drain();
    chk("pp_dlv0", dlv0, 5);
    // reset with three requests outstanding and priority on bank 1
    do_reset(1);
    load(0, 0, 8'h50, 32'h7000);
    load(1, 0, 8'h51, 32'h7100);
    load(0, 0, 8'h52, 32'h7010);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 1, 1);
    chk("mid_prio_bank1", prio, 1);
    do_reset(1);
    load(0, 0, 8'h60, 32'h8000);
    load(1, 0, 8'h61, 32'h8100);
    cycle(1, 1, 1, 0, 1, 1);
    chk("post_rst_grant0", in0_req_rdy, 1);
    chk("post_rst_no_grant1", in1_req_rdy, 0);
    chk("post_rst_empty", memresp_rdy, 0);
    drain();
    // randomized mixed traffic
    do_reset(1);
    for (int i = 0; i < 500; i++)
      load(1'($urandom), 1'($urandom), 8'($urandom), $urandom);
    for (int n = 0; n < 20000 && (src0.size() + src1.size() + idq.size()) != 0; n++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    chk("rand_delivered", dlv0 + dlv1, 500);
    chk("rand_sb_empty", exp0.size() + exp1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
